pc_sequencer: RTL

//   Program-counter sequencer for the 9-bit ISA core; owns the PC register and drives the

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 9-bit ISA core: PC register, branch/call/return next-PC,
// IDLE/RUN/HALT lifecycle and retired-instruction count. Optional link register: PC_LINK_EN.
module pc_sequencer #(
   parameter int D     = 9,
   parameter int LUT_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             branch_en,
   input  logic             branch_cond,
   input  logic [LUT_W-1:0] branch_idx,
   input  logic             call_en,
   input  logic             ret_en,
   output logic [LUT_W-1:0] lut_addr,
   input  logic [D-1:0]     lut_target,
   output logic [D-1:0]     prog_ctr,
   output logic             fetch_en,
   output logic             done,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t         state;
   state_t         stateNext;
   logic [D-1:0]   pcNext;
   logic [D-1:0]   pcPlusOne;
   logic [CNT_W-1:0] cntNext;
   logic           retire;

`ifdef PC_LINK_EN
   logic [D-1:0]   link;
   logic [D-1:0]   linkNext;
`else
   logic           unusedRet;
   assign unusedRet = ret_en;
`endif

   assign pcPlusOne = prog_ctr + {{(D-1){1'b0}}, 1'b1};
   assign retire    = (state == RUN) && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // A halting instruction only takes effect when it actually retires (not stalled).
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = RUN;
         RUN:     if (!stall && halt_req) stateNext = HALT;
         HALT:    if (start) stateNext = RUN;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      pcNext  = prog_ctr;
      cntNext = instr_cnt;
`ifdef PC_LINK_EN
      linkNext = link;
`endif
      if (state == IDLE || state == HALT) begin
         if (start) begin
            pcNext  = '0;
            cntNext = '0;
         end
      end else if (retire) begin
         if (instr_cnt != '1) begin
            cntNext = instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         // Priority: halt, return, call, taken branch, sequential.
         if (halt_req) begin
            pcNext = prog_ctr;
`ifdef PC_LINK_EN
         end else if (ret_en) begin
            pcNext = link;
         end else if (call_en) begin
            linkNext = pcPlusOne;
            pcNext   = lut_target;
`else
         end else if (call_en) begin
            pcNext = lut_target;
`endif
         end else if (branch_en && branch_cond) begin
            pcNext = lut_target;
         end else begin
            pcNext = pcPlusOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prog_ctr  <= '0;
         instr_cnt <= '0;
`ifdef PC_LINK_EN
         link      <= '0;
`endif
      end else begin
         prog_ctr  <= pcNext;
         instr_cnt <= cntNext;
`ifdef PC_LINK_EN
         link      <= linkNext;
`endif
      end
   end

   always_comb begin
      fetch_en = retire;
      done     = (state == HALT);
      lut_addr = branch_idx;
   end

endmodule
